xbar_slave_arbiter: RTL and testbench

- Slave-port stage of the crossbar, directly downstream of two master_device instances.
- Decodes each master's request address, arbitrates round-robin between masters targeting this slave, forwards the winning request to the slave and routes ack/resp/rdata back to the winner.
- One instance per slave port.

---
 rtl/xbar_slave_arbiter.sv | 171 +++++++++++++++++
 tb/tb_xbar_slave_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_slave_arbiter.sv
// -----------------------------------------------------------------------------
// xbar_slave_arbiter
//
// Slave-port stage of the crossbar. It sits directly downstream of two master
// ports. It decodes each master's address MSB against SLAVE_ID and picks one
// hitting master (round-robin by default). It forwards that master's request to
// the slave, then routes the slave's ack, resp and rdata back to the winner.
// Only one transaction is in flight at a time; a read holds the port until the
// slave returns its response.
//
// Optional feature (compile-time macro XBAR_ARB_FIXED_PRIO_EN):
//   defined   -> fixed priority, master 0 wins whenever both masters hit;
//                no round-robin pointer exists.
//   undefined -> round-robin; the pointer flips to the non-granted master on
//                every slave ack.
//
// Ports:
//   clk, rst_in                 clock (rising edge), async active-low reset
//   mX_req/cmd/addr/wdata       master X request (cmd: 0 = read, 1 = write)
//   mX_ack                      request accepted, one-cycle pulse
//   mX_resp/rdata               read data valid pulse and data (0 otherwise)
//   s_req                       registered request to slave
//   s_cmd/s_addr/s_wdata        forwarded request fields, 0 while s_req = 0
//   s_ack, s_resp, s_rdata      slave handshake and read data
// -----------------------------------------------------------------------------
module xbar_slave_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32,
    parameter bit SLAVE_ID   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  m0_req,
    input  logic                  m0_cmd,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic                  m0_resp,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_cmd,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic                  m1_resp,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  s_req,
    output logic                  s_cmd,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_wdata,
    input  logic                  s_ack,
    input  logic                  s_resp,
    input  logic [DATA_WIDTH-1:0] s_rdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   s_req_q, s_req_d;
    logic   m0_hit, m1_hit;
    logic   tie_pick;
    logic   winner;
    logic   sel_cmd;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    assign m0_hit = m0_req && (m0_addr[ADDR_WIDTH-1] == SLAVE_ID);
    assign m1_hit = m1_req && (m1_addr[ADDR_WIDTH-1] == SLAVE_ID);

`ifdef XBAR_ARB_FIXED_PRIO_EN
    assign tie_pick = 1'b0;
`else
    logic rr_q, rr_d;
    assign tie_pick = rr_q;
`endif

    // Tie goes to tie_pick; otherwise the single hitting master (m1 iff it hits).
    assign winner = (m0_hit && m1_hit) ? tie_pick : m1_hit;

    assign sel_cmd   = grant_q ? m1_cmd   : m0_cmd;
    assign sel_addr  = grant_q ? m1_addr  : m0_addr;
    assign sel_wdata = grant_q ? m1_wdata : m0_wdata;

    assign s_req = s_req_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        s_req_d  = s_req_q;
`ifndef XBAR_ARB_FIXED_PRIO_EN
        rr_d     = rr_q;
`endif
        s_cmd    = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        m0_resp  = 1'b0;
        m1_resp  = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;

        case (state_q)
            IDLE: begin
                if (m0_hit || m1_hit) begin
                    grant_d = winner;
                    s_req_d = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Masters hold their request fields until acked, so a live mux
                // keeps the forwarded bus stable for the whole GRANT phase.
                s_cmd   = sel_cmd;
                s_addr  = sel_addr;
                s_wdata = sel_wdata;
                m0_ack  = s_ack && !grant_q;
                m1_ack  = s_ack && grant_q;
                if (s_ack) begin
                    s_req_d = 1'b0;
`ifndef XBAR_ARB_FIXED_PRIO_EN
                    rr_d    = ~grant_q;
`endif
                    state_d = sel_cmd ? IDLE : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                m0_resp = s_resp && !grant_q;
                m1_resp = s_resp && grant_q;
                // rdata is only meaningful alongside resp; keep it 0 otherwise.
                if (s_resp && !grant_q) m0_rdata = s_rdata;
                if (s_resp && grant_q)  m1_rdata = s_rdata;
                if (s_resp) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                s_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            s_req_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            s_req_q <= s_req_d;
        end
    end

`ifndef XBAR_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// -----------------------------------------------------------------------------
// tb_xbar_slave_arbiter
//
// Directed bench for xbar_slave_arbiter with SLAVE_ID = 0. It drives the
// masters and the slave by hand and compares outputs against hand-computed
// values. Inputs change at negedge or just after posedge. Outputs are sampled
// at negedge, or #1 after a negedge input change.
// -----------------------------------------------------------------------------
module tb_xbar_slave_arbiter;

    localparam int DW = 16;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          m0_req, m0_cmd, m0_ack, m0_resp;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_cmd, m1_ack, m1_resp;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          s_req, s_cmd, s_ack, s_resp;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    xbar_slave_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .SLAVE_ID   (1'b0)
    ) dut (
        .clk      (clk),
        .rst_in   (rst_in),
        .m0_req   (m0_req),
        .m0_cmd   (m0_cmd),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_resp  (m0_resp),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_cmd   (m1_cmd),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_resp  (m1_resp),
        .m1_rdata (m1_rdata),
        .s_req    (s_req),
        .s_cmd    (s_cmd),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_ack    (s_ack),
        .s_resp   (s_resp),
        .s_rdata  (s_rdata)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns at a negedge where s_req is high, or after a bounded wait.
    task automatic wait_sreq(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (s_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, " s_req"}, 32'(s_req), 32'h1);
    endtask

    // Slave acks at a negedge; checks routing, then releases s_ack after the edge.
    task automatic ack_grant(input string tag, input int who);
        s_ack = 1'b1;
        #1;
        check_val({tag, " m0_ack"}, 32'(m0_ack), (who == 0) ? 32'h1 : 32'h0);
        check_val({tag, " m1_ack"}, 32'(m1_ack), (who == 1) ? 32'h1 : 32'h0);
        @(posedge clk);
        #1;
        s_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int exp_m;
        rst_in   = 1'b0;
        m0_req   = 1'b0; m0_cmd = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req   = 1'b0; m1_cmd = 1'b0; m1_addr = '0; m1_wdata = '0;
        s_ack    = 1'b0; s_resp = 1'b0; s_rdata = '0;

        // Reset held with a live request and noisy slave inputs
        m0_req = 1'b1; m0_cmd = 1'b1; m0_addr = 32'h0000_1000; m0_wdata = 16'hA5A5;
        s_ack = 1'b1; s_resp = 1'b1; s_rdata = 16'hFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst s_req",    32'(s_req),    32'h0);
        check_val("rst m0_ack",   32'(m0_ack),   32'h0);
        check_val("rst m1_ack",   32'(m1_ack),   32'h0);
        check_val("rst m0_resp",  32'(m0_resp),  32'h0);
        check_val("rst m1_resp",  32'(m1_resp),  32'h0);
        check_val("rst m0_rdata", 32'(m0_rdata), 32'h0);
        check_val("rst s_wdata",  32'(s_wdata),  32'h0);
        check_val("rst s_addr",   s_addr,        32'h0);
        s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
        rst_in = 1'b1;
        #1;
        check_val("post-rst s_req", 32'(s_req), 32'h0);

        // Single write from m0, slave acks two cycles after s_req
        @(negedge clk);
        check_val("wr s_req",   32'(s_req),   32'h1);
        check_val("wr s_wdata", 32'(s_wdata), 32'hA5A5);
        check_val("wr s_addr",  s_addr,       32'h0000_1000);
        check_val("wr s_cmd",   32'(s_cmd),   32'h1);
        check_val("wr m0_ack early", 32'(m0_ack), 32'h0);
        @(negedge clk);
        check_val("wr s_req hold", 32'(s_req), 32'h1);
        @(negedge clk);
        ack_grant("wr", 0);
        m0_req = 1'b0;
        @(negedge clk);
        check_val("wr done s_req",   32'(s_req),   32'h0);
        check_val("wr done m0_ack",  32'(m0_ack),  32'h0);
        check_val("wr done s_wdata", 32'(s_wdata), 32'h0);

        // Single read from m1, response three cycles after ack
        m1_req = 1'b1; m1_cmd = 1'b0; m1_addr = 32'h0000_2000; m1_wdata = 16'h0000;
        wait_sreq("rd");
        check_val("rd s_addr", s_addr,      32'h0000_2000);
        check_val("rd s_cmd",  32'(s_cmd),  32'h0);
        ack_grant("rd", 1);
        m1_req = 1'b0;
        @(negedge clk);
        check_val("rd wait s_req",  32'(s_req), 32'h0);
        check_val("rd wait s_addr", s_addr,     32'h0);
        s_ack = 1'b1;
        #1;
        check_val("rd stray ack m1", 32'(m1_ack), 32'h0);
        s_ack = 1'b0;
        repeat (2) @(negedge clk);
        s_resp = 1'b1; s_rdata = 16'h1234;
        #1;
        check_val("rd m1_resp",  32'(m1_resp),  32'h1);
        check_val("rd m1_rdata", 32'(m1_rdata), 32'h1234);
        check_val("rd m0_rdata", 32'(m0_rdata), 32'h0);
        check_val("rd m0_resp",  32'(m0_resp),  32'h0);
        @(posedge clk);
        #1;
        s_resp = 1'b0; s_rdata = '0;

        // Slave response outside WAIT_RESP is ignored
        @(negedge clk);
        s_resp = 1'b1; s_rdata = 16'hFFFF;
        #1;
        check_val("idle resp m1",  32'(m1_resp),  32'h0);
        check_val("idle rdata m1", 32'(m1_rdata), 32'h0);
        check_val("idle resp m0",  32'(m0_resp),  32'h0);
        check_val("idle s_req",    32'(s_req),    32'h0);
        s_resp = 1'b0; s_rdata = '0;

        // Continuous contention: both masters write; pointer starts at m0
        m0_req = 1'b1; m0_cmd = 1'b1; m0_addr = 32'h0000_0010; m0_wdata = 16'h0A0A;
        m1_req = 1'b1; m1_cmd = 1'b1; m1_addr = 32'h0000_0020; m1_wdata = 16'h1B1B;
        for (int k = 0; k < 4; k++) begin
`ifdef XBAR_ARB_FIXED_PRIO_EN
            exp_m = 0;
`else
            exp_m = k % 2;
`endif
            wait_sreq($sformatf("arb%0d", k));
            check_val($sformatf("arb%0d s_wdata", k), 32'(s_wdata),
                      (exp_m == 1) ? 32'h1B1B : 32'h0A0A);
            ack_grant($sformatf("arb%0d", k), exp_m);
        end
        m0_req = 1'b0; m1_req = 1'b0;

        // Decode miss on m0 while m1 hits
        @(negedge clk);
        m0_req = 1'b1; m0_cmd = 1'b1; m0_addr = 32'h8000_0000; m0_wdata = 16'h5A5A;
        m1_req = 1'b1; m1_cmd = 1'b1; m1_addr = 32'h0000_3000; m1_wdata = 16'h7777;
        wait_sreq("miss");
        check_val("miss s_wdata", 32'(s_wdata), 32'h7777);
        check_val("miss s_addr",  s_addr,       32'h0000_3000);
        ack_grant("miss", 1);
        m1_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val($sformatf("miss idle%0d s_req", i), 32'(s_req), 32'h0);
            check_val($sformatf("miss idle%0d m0_ack", i), 32'(m0_ack), 32'h0);
        end
        m0_req = 1'b0;

        // Reset during WAIT_RESP drops the late response
        m0_req = 1'b1; m0_cmd = 1'b0; m0_addr = 32'h0000_4000; m0_wdata = 16'h0000;
        wait_sreq("mrst");
        ack_grant("mrst", 0);
        m0_req = 1'b0;
        @(negedge clk);
        rst_in = 1'b0;
        #1;
        check_val("mrst s_req", 32'(s_req), 32'h0);
        @(negedge clk);
        rst_in = 1'b1;
        s_resp = 1'b1; s_rdata = 16'h5555;
        #1;
        check_val("mrst m0_resp",  32'(m0_resp),  32'h0);
        check_val("mrst m0_rdata", 32'(m0_rdata), 32'h0);
        check_val("mrst m1_resp",  32'(m1_resp),  32'h0);
        @(posedge clk);
        #1;
        s_resp = 1'b0; s_rdata = '0;

        // Pointer cleared by reset: a tie goes back to m0
        m0_req = 1'b1; m0_cmd = 1'b1; m0_addr = 32'h0000_0010; m0_wdata = 16'h0A0A;
        m1_req = 1'b1; m1_cmd = 1'b1; m1_addr = 32'h0000_0020; m1_wdata = 16'h1B1B;
        wait_sreq("rrrst");
        check_val("rrrst s_wdata", 32'(s_wdata), 32'h0A0A);
        ack_grant("rrrst", 0);
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
